// File: rtl/pps_period_meter.sv
// GPS 1PPS period meter: counts CLK_SYS cycles between synchronized PPS rising
// edges, range-checks each period and reports lock health to the loop filter.
module pps_period_meter #(
    parameter int NOMINAL     = 1_000_000,
    parameter int WINDOW      = 50_000,
    parameter int GOOD_NEEDED = 3
) (
    input  logic        CLK_SYS,
    input  logic        CLK_RST,
    input  logic        GPS_PPS,
    output logic [23:0] Measure_Phase,
    output logic        Measure_Done,
    output logic        Pps_Valid,
    output logic        Pps_Lost,
    output logic [7:0]  Err_Cnt
);
    localparam int              GW       = $clog2(GOOD_NEEDED + 1);
    localparam logic [23:0]     LO       = 24'(NOMINAL - WINDOW);
    localparam logic [23:0]     HI       = 24'(NOMINAL + WINDOW);
    localparam logic [GW-1:0]   GOOD_MAX = GW'(GOOD_NEEDED);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [2:0]     r_sync;
    logic [23:0]    r_cnt;
    logic [23:0]    r_phase;
    logic           r_done_stage;
    logic           r_done;
    logic           r_valid;
    logic           r_lost;
    logic [7:0]     r_err;
    logic [GW-1:0]  r_good_run;

    logic           w_edge;
    logic [23:0]    w_period;
    logic           w_good_edge;
    logic           w_bad_edge;
    logic           w_timeout;
    logic [GW-1:0]  w_good_run_inc;

    // r_sync[1:0] is the metastability pair, r_sync[2] the delayed copy for edge detect
    assign w_edge         = r_sync[1] & ~r_sync[2];
    assign w_period       = r_cnt + 24'd1;
    assign w_good_run_inc = (r_good_run == GOOD_MAX) ? GOOD_MAX : r_good_run + GW'(1);

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An edge on the timeout cycle takes priority and is judged as a (bad) period
    always_comb begin
        w_state_next = r_state;
        w_good_edge  = 1'b0;
        w_bad_edge   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_next = COUNT;
                end
            end
            COUNT: begin
                if (w_edge) begin
                    if (w_period >= LO && w_period <= HI) begin
                        w_good_edge = 1'b1;
                    end else begin
                        w_bad_edge = 1'b1;
                    end
                end else if (w_period == HI + 24'd1) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_sync       <= '0;
            r_cnt        <= '0;
            r_phase      <= '0;
            r_done_stage <= 1'b0;
            r_done       <= 1'b0;
            r_valid      <= 1'b0;
            r_lost       <= 1'b1;
            r_err        <= '0;
            r_good_run   <= '0;
        end else begin
            r_sync       <= {r_sync[1:0], GPS_PPS};
            // Done trails the phase load by one cycle so data is settled before the pulse
            r_done_stage <= w_good_edge;
            r_done       <= r_done_stage;

            if (r_state == IDLE || w_edge || w_timeout) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_period;
            end

            if (w_good_edge) begin
                r_phase    <= w_period;
                r_good_run <= w_good_run_inc;
                r_lost     <= 1'b0;
                if (w_good_run_inc == GOOD_MAX) begin
                    r_valid <= 1'b1;
                end
            end else if (w_bad_edge) begin
                if (r_err != 8'hFF) begin
                    r_err <= r_err + 8'd1;
                end
                r_good_run <= '0;
                r_valid    <= 1'b0;
            end else if (w_timeout) begin
                r_lost     <= 1'b1;
                r_valid    <= 1'b0;
                r_good_run <= '0;
            end
        end
    end

    assign Measure_Phase = r_phase;
    assign Measure_Done  = r_done;
    assign Pps_Valid     = r_valid;
    assign Pps_Lost      = r_lost;
    assign Err_Cnt       = r_err;

endmodule

// File: tb/tb_pps_period_meter.sv
// Randomized scoreboard bench for pps_period_meter: an edge-time reference model
// predicts accepted periods and health flags; a monitor checks every Done pulse.
module tb_pps_period_meter;
    localparam int NOM = 1000;
    localparam int WIN = 50;
    localparam int GN  = 3;
    localparam int LO  = NOM - WIN;
    localparam int HI  = NOM + WIN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pps;
    logic [23:0] phase;
    logic        done;
    logic        valid;
    logic        lost;
    logic [7:0]  err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;

    // Reference model state: edge times in clock cycles
    bit m_armed;
    int m_last;
    int m_err, m_good, m_valid, m_lost, m_phase;
    int exp_q[$];

    pps_period_meter #(
        .NOMINAL     (NOM),
        .WINDOW      (WIN),
        .GOOD_NEEDED (GN)
    ) dut (
        .CLK_SYS       (clk),
        .CLK_RST       (rst_n),
        .GPS_PPS       (pps),
        .Measure_Phase (phase),
        .Measure_Done  (done),
        .Pps_Valid     (valid),
        .Pps_Lost      (lost),
        .Err_Cnt       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        m_armed = 1'b0;
        m_last  = 0;
        m_err   = 0;
        m_good  = 0;
        m_valid = 0;
        m_lost  = 1;
        m_phase = 0;
        exp_q.delete();
    endfunction

    function automatic void model_timeout();
        m_lost  = 1;
        m_valid = 0;
        m_good  = 0;
        m_armed = 1'b0;
    endfunction

    function automatic void model_edge(input int t);
        int p;
        if (m_armed && (t - m_last) > HI + 1) model_timeout();
        if (!m_armed) begin
            m_armed = 1'b1;
            m_last  = t;
            return;
        end
        p      = t - m_last;
        m_last = t;
        if (p >= LO && p <= HI) begin
            exp_q.push_back(p);
            m_phase = p;
            m_good  = (m_good + 1 > GN) ? GN : m_good + 1;
            if (m_good == GN) m_valid = 1;
            m_lost = 0;
        end else begin
            m_err   = (m_err + 1 > 255) ? 255 : m_err + 1;
            m_good  = 0;
            m_valid = 0;
        end
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_err"},     int'(err),   m_err);
        chk({tag, "_valid"},   int'(valid), m_valid);
        chk({tag, "_lost"},    int'(lost),  m_lost);
        chk({tag, "_phase"},   int'(phase), m_phase);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_phase"}, int'(phase), 0);
        chk({tag, "_done"},  int'(done),  0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_lost"},  int'(lost),  1);
        chk({tag, "_err"},   int'(err),   0);
    endtask

    // One rising edge now, next edge n cycles later; status sampled 6 cycles after the edge
    task automatic run_period(input int n, input string tag);
        @(negedge clk);
        pps = 1'b1;
        model_edge(cyc);
        @(negedge clk);
        @(negedge clk);
        pps = 1'b0;
        repeat (4) @(negedge clk);
        check_status(tag);
        repeat (n - 7) @(negedge clk);
    endtask

    // Scoreboard monitor
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                n_done++;
                chk("done_width", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("done_phase", int'(phase), e);
                    $display("done %0d: phase=%0d expected=%0d valid=%0d err=%0d",
                             n_done, phase, e, valid, err);
                end
            end
            prev_done = done;
        end
    end

    int seq_a[16] = '{1000, 1000, 1000, 1000, 950, 1050, 949, 1051,
                      1000, 1000, 1000, 400, 600, 1000, 1000, 1000};
    int bnd[6]    = '{949, 950, 1050, 1051, 1052, 1200};

    initial begin
        rst_n = 1'b0;
        pps   = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Lock, window boundaries, glitch split
        foreach (seq_a[i]) run_period(seq_a[i], "seq");

        // PPS stops: not lost before the timeout, lost after it
        run_period(1040, "stop_last");
        @(negedge clk);
        if (m_armed && (cyc - m_last) > HI + 3) model_timeout();
        chk("stop_early_lost", int'(lost), m_lost);
        repeat (20) @(negedge clk);
        if (m_armed && (cyc - m_last) > HI + 3) model_timeout();
        chk("stop_lost",  int'(lost),  m_lost);
        chk("stop_valid", int'(valid), m_valid);
        for (int i = 0; i < 3; i++) run_period(1000, "relock");

        // Asynchronous reset in the middle of a period
        run_period(600, "pre_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run_period(1000, "postreset");

        // Randomized period mix
        for (int i = 0; i < 15; i++) begin
            int k, n;
            k = $urandom_range(0, 3);
            if (k <= 1)      n = $urandom_range(LO, HI);
            else if (k == 2) n = $urandom_range(20, LO - 1);
            else             n = bnd[$urandom_range(0, 5)];
            run_period(n, "rand");
        end

        // Error counter saturation
        for (int i = 0; i < 300; i++) run_period($urandom_range(20, 150), "sat");
        run_period(100, "sat_end");
        chk("err_saturated", int'(err), 255);

        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
